// File: rtl/cache_dm_line_if.sv
// rtl/cache_dm_line_if.sv - CPU and memory-side signal bundle for cache_dm_line
interface cache_dm_line_if #(
  parameter int CNT_W = 16
);
  logic             read;
  logic             write;
  logic [31:0]      adbus;
  logic [31:0]      cpu_wdata;
  logic [31:0]      cpu_rdata;
  logic             ready;
  logic             grant;
  logic             read_mem;
  logic             write_mem;
  logic             grant_mem;
  logic             ready_mem;
  logic [31:0]      mem_adbus;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  modport slave (
    input  read, write, adbus, cpu_wdata, grant_mem, ready_mem, mem_rdata,
    output cpu_rdata, ready, grant, read_mem, write_mem, mem_adbus, mem_wdata,
           hit_count, miss_count
  );

  modport master (
    output read, write, adbus, cpu_wdata, grant_mem, ready_mem, mem_rdata,
    input  cpu_rdata, ready, grant, read_mem, write_mem, mem_adbus, mem_wdata,
           hit_count, miss_count
  );
endinterface

// File: rtl/cache_dm_line.sv
// rtl/cache_dm_line.sv - direct-mapped multi-word-line cache, WT/no-allocate or WB/allocate
module cache_dm_line #(
  parameter int SETS       = 128,
  parameter int SET_BITS   = 7,
  parameter int LINE_WORDS = 4,
  parameter int WORD_BITS  = 2,
  parameter int WRITE_BACK = 0,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  cache_dm_line_if.slave bus
);
  localparam int TAG_W = 30 - WORD_BITS - SET_BITS;
  localparam int IDX_W = SET_BITS + WORD_BITS;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, WT_WRITE, RESPOND} state_t;
  state_t state, state_n;

  logic [31:0]      data_ram [SETS*LINE_WORDS];
  logic [TAG_W-1:0] tag_ram  [SETS];
  logic [SETS-1:0]  valid, dirty;

  logic                 req_wr;
  logic [WORD_BITS-1:0] req_word;
  logic [SET_BITS-1:0]  req_set;
  logic [TAG_W-1:0]     req_tag;
  logic [31:0]          req_wdata;
  logic [WORD_BITS-1:0] k;
  logic [CNT_W-1:0]     hit_cnt, miss_cnt;

  logic [IDX_W-1:0] req_idx, beat_idx;
  logic             hit, victim_dirty, beat, last_beat;
  logic             unused_addr_bits;

  assign req_idx          = {req_set, req_word};
  assign beat_idx         = {req_set, k};
  assign hit              = valid[req_set] && (tag_ram[req_set] == req_tag);
  assign victim_dirty     = valid[req_set] && dirty[req_set];
  assign beat             = bus.grant_mem && bus.ready_mem;
  assign last_beat        = beat && (&k);
  assign unused_addr_bits = ^bus.adbus[1:0];

  logic        ready_c, grant_c, read_mem_c, write_mem_c;
  logic [31:0] mem_adbus_c, mem_wdata_c, cpu_rdata_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    ready_c     = 1'b0;
    grant_c     = 1'b1;
    read_mem_c  = 1'b0;
    write_mem_c = 1'b0;
    mem_adbus_c = '0;
    mem_wdata_c = '0;
    cpu_rdata_c = '0;
    case (state)
      IDLE: begin
        grant_c = 1'b0;
        if (bus.read || bus.write) state_n = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          if (req_wr && WRITE_BACK == 0) state_n = WT_WRITE;
          else                           state_n = RESPOND;
        end else if (req_wr && WRITE_BACK == 0) begin
          state_n = WT_WRITE;
        end else if (WRITE_BACK != 0 && victim_dirty) begin
          state_n = EVICT;
        end else begin
          state_n = FILL;
        end
      end
      EVICT: begin
        write_mem_c = 1'b1;
        if (bus.grant_mem) begin
          mem_adbus_c = {tag_ram[req_set], req_set, k, 2'b00};
          mem_wdata_c = data_ram[beat_idx];
        end
        if (last_beat) state_n = FILL;
      end
      FILL: begin
        read_mem_c = 1'b1;
        if (bus.grant_mem) mem_adbus_c = {req_tag, req_set, k, 2'b00};
        if (last_beat) state_n = RESPOND;
      end
      WT_WRITE: begin
        write_mem_c = 1'b1;
        if (bus.grant_mem) begin
          mem_adbus_c = {req_tag, req_set, req_word, 2'b00};
          mem_wdata_c = req_wdata;
        end
        if (beat) state_n = RESPOND;
      end
      RESPOND: begin
        ready_c = 1'b1;
        if (!req_wr) cpu_rdata_c = data_ram[req_idx];
        if (!bus.read && !bus.write) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ready      = ready_c;
  assign bus.grant      = grant_c;
  assign bus.read_mem   = read_mem_c;
  assign bus.write_mem  = write_mem_c;
  assign bus.mem_adbus  = mem_adbus_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.cpu_rdata  = cpu_rdata_c;
  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_wr    <= 1'b0;
      req_word  <= '0;
      req_set   <= '0;
      req_tag   <= '0;
      req_wdata <= '0;
      k         <= '0;
      valid     <= '0;
      dirty     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.read || bus.write) begin
            req_wr    <= bus.write;
            req_word  <= bus.adbus[WORD_BITS+1:2];
            req_set   <= bus.adbus[IDX_W+1:WORD_BITS+2];
            req_tag   <= bus.adbus[31:IDX_W+2];
            req_wdata <= bus.cpu_wdata;
            k         <= '0;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (~&hit_cnt) hit_cnt <= hit_cnt + CNT_W'(1);
            if (req_wr && WRITE_BACK != 0) dirty[req_set] <= 1'b1;
          end else begin
            if (~&miss_cnt) miss_cnt <= miss_cnt + CNT_W'(1);
          end
        end
        EVICT: begin
          if (beat) begin
            k <= k + WORD_BITS'(1);
            if (&k) dirty[req_set] <= 1'b0;
          end
        end
        FILL: begin
          if (beat) begin
            k <= k + WORD_BITS'(1);
            if (&k) begin
              valid[req_set] <= 1'b1;
              if (req_wr && WRITE_BACK != 0) dirty[req_set] <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Storage arrays carry no reset; validity is tracked only by valid[].
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && req_wr) data_ram[req_idx] <= req_wdata;
    if (state == FILL && beat) begin
      data_ram[beat_idx] <= (req_wr && k == req_word) ? req_wdata : bus.mem_rdata;
      if (&k) tag_ram[req_set] <= req_tag;
    end
  end
endmodule

// File: doc/cache_dm_line.md
Name: cache_dm_line

Overview:
- Synthesizable, parametrised direct-mapped cache between the CPU data port and the memory arbiter.
- Next generation of the single-word behavioural cache: multi-word lines and burst line fill.
- Mode is selectable: write-through/no-allocate or write-back/write-allocate with dirty eviction.
- Adds hit/miss statistics counters. Separate read/write data buses replace the bidirectional ones.

Parameters:
- SETS, 128, number of lines (power of 2).
- SET_BITS, 7, log2(SETS).
- LINE_WORDS, 4, 32-bit words per line (power of 2, >=2).
- WORD_BITS, 2, log2(LINE_WORDS).
- WRITE_BACK, 0, 0 = write-through/no-allocate; 1 = write-back/write-allocate.
- CNT_W, 16, width of the statistics counters.
- Derived: TAG_W = 30-WORD_BITS-SET_BITS (21 at defaults).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- read  in  1  CPU read request, held until ready seen.
- write  in  1  CPU write request, held until ready seen; read and write are never both high.
- adbus  in  32  CPU byte address; [1:0] ignored.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  CPU read data, valid while ready=1 on a read.
- ready  out  1  transaction complete.
- grant  out  1  request accepted and in progress.
- read_mem  out  1  memory burst-read request.
- write_mem  out  1  memory write request (single word or burst).
- grant_mem  in  1  memory arbiter grant.
- ready_mem  in  1  one beat transferred this cycle.
- mem_adbus  out  32  word address of the current beat.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, sampled when ready_mem=1.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; mem_adbus, cpu_rdata, mem_wdata = 0; counters = 0.
  - valid[] and dirty[] flop vectors cleared; FSM to IDLE.
  - Data and tag RAM are not reset.
  - Reset mid-burst abandons the transfer and leaves no line valid.
- Address split: word = adbus[WORD_BITS+1:2]; set = next SET_BITS bits; tag = upper TAG_W bits.
- States: IDLE, LOOKUP, EVICT, FILL, WT_WRITE, RESPOND.
  - IDLE: read|write sampled → latch address and data, grant=1, go to LOOKUP.
  - LOOKUP (1 cycle): hit = valid[set] && tag[set]==tag.
    - Hit: count hit.
    - Miss: count miss.
    - Read hit → RESPOND.
    - Write hit, WT: update word → WT_WRITE.
    - Write hit, WB: update word, set dirty → RESPOND.
    - Read miss, or WB write miss: if WB and the victim is valid and dirty → EVICT, else → FILL.
    - WT write miss: no allocate → WT_WRITE.
  - EVICT: write_mem=1 held through the burst.
    - On each ready_mem: drive victim word k, mem_adbus = {victim_tag, set, k, 2'b00}, k increments.
    - Last beat → clear dirty → FILL.
  - FILL: read_mem=1; mem_adbus = {tag, set, k, 2'b00}.
    - Each ready_mem beat writes mem_rdata into word k.
    - After LINE_WORDS beats: set valid, write tag, merge a pending write (WB: set dirty) → RESPOND.
  - WT_WRITE: write_mem=1, mem_adbus = latched address, mem_wdata = cpu data; one ready_mem beat → RESPOND.
  - RESPOND: ready=1; on reads cpu_rdata = line word.
    - ready is held until read and write are both 0; then ready=0 and grant=0 next cycle → IDLE.
- Memory handshake:
  - Address and data are driven only after grant_mem=1.
  - Beats may stall: ready_mem low adds wait cycles.
  - read_mem/write_mem drop the cycle after the final beat.
- Latency: read hit asserts ready 2 cycles after the request is sampled. A clean miss takes 2 + LINE_WORDS + grant/stall cycles.
- Beat counter k wraps at LINE_WORDS; the fill always starts at word 0.
- Counters saturate at all-ones.
- Request changes while the FSM is busy are ignored. The latched copy is used.

Test Plan:
- Reset, then read 0x0000_0100 with memory returning 0xA0..0xA3 over 4 beats → 4 beats at mem_adbus 0x100, 0x104, 0x108, 0x10C; cpu_rdata=0xA0; miss_count=1.
- Read 0x0000_0108 next → hit; ready 2 cycles after the request; cpu_rdata=0xA2; no mem activity; hit_count=1.
- WT mode, write 0xDEADBEEF to 0x0000_0104 (hit) → one write_mem beat at 0x104 with 0xDEADBEEF; a later read returns 0xDEADBEEF.
- WT mode, write miss to 0x0000_2000 → single memory write; no fill; valid for set 0 stays 0.
- WB mode, dirty the line at 0x100, then read 0x0000_0900 (same set 0x10) → 4-beat evict at 0x100..0x10C with the modified word, then 4-beat fill at 0x900..0x90C.
- Assert rst_n=0 during FILL beat 2 → read_mem/ready/grant go to 0 immediately; a subsequent read of the same address misses again.
